game_seq_ctrl: RTL and testbench

GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

---
 rtl/game_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl.sv
// Game sequencer: start-button synchroniser, SERVE/PLAY/LOST/OVER flow, lives and score.
// Optional pause in PLAY is built when GAME_SEQ_CTRL_PAUSE_EN is defined.
module game_seq_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned LOST_FRAMES  = 30,
    parameter int unsigned LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       ball_lost,
    input  logic       brick_hit,
    output logic       eng_rst_n,
    output logic       eng_run,
    output logic       overlay_en,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [2:0] state
);

`ifdef GAME_SEQ_CTRL_PAUSE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;
`endif

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] LOST_LAST  = 8'(LOST_FRAMES - 1);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0] settle_q;
    logic       start_rise;

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [7:0] cnt_q, cnt_d;
    logic       eng_rst_n_q, eng_rst_n_d;
    logic       eng_run_q, eng_run_d;
    logic       overlay_en_q, overlay_en_d;

    // Edges are accepted only after the chain has refilled from reset and
    // been seen low, so a button held through reset release is not a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            sync1_q <= btn_start;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2 && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start_rise = sync2_q & ~prev_q & armed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            score_q      <= 8'd0;
            cnt_q        <= 8'd0;
            eng_rst_n_q  <= 1'b0;
            eng_run_q    <= 1'b0;
            overlay_en_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            eng_rst_n_q  <= eng_rst_n_d;
            eng_run_q    <= eng_run_d;
            overlay_en_q <= overlay_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    lives_d = LIVES_LOAD;
                    score_d = 8'd0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (brick_hit) begin
                    score_d = sat_inc8(score_q);
                end
                if (ball_lost) begin
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                    state_d = ST_LOST;
                end
`ifdef GAME_SEQ_CTRL_PAUSE_EN
                else if (start_rise) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
`ifdef GAME_SEQ_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            ST_LOST: begin
                if (frame_tick) begin
                    if (cnt_q == LOST_LAST) begin
                        state_d = (lives_q != 2'd0) ? ST_SERVE : ST_OVER;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they move with the state register.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end
        eng_rst_n_d  = !(state_d == ST_SERVE && state_q != ST_SERVE);
        eng_run_d    = (state_d == ST_PLAY);
        overlay_en_d = (state_d == ST_IDLE) || (state_d == ST_OVER);
    end

    assign eng_rst_n  = eng_rst_n_q;
    assign eng_run    = eng_run_q;
    assign overlay_en = overlay_en_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed game flow plus randomized play checked against a
// rule-level model of the sequencer (honours GAME_SEQ_CTRL_PAUSE_EN when defined).
module tb_game_seq_ctrl;
    localparam int SF = 4;
    localparam int LF = 2;
    localparam int LI = 3;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_LOST  = 3;
    localparam int S_OVER  = 4;
    localparam int S_PAUSE = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       ball_lost = 1'b0;
    logic       brick_hit = 1'b0;
    logic       eng_rst_n, eng_run, overlay_en;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;

    game_seq_ctrl #(
        .SERVE_FRAMES(SF),
        .LOST_FRAMES (LF),
        .LIVES_INIT  (LI)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_start (btn_start),
        .ball_lost (ball_lost),
        .brick_hit (brick_hit),
        .eng_rst_n (eng_rst_n),
        .eng_run   (eng_run),
        .overlay_en(overlay_en),
        .lives     (lives),
        .score     (score),
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_state, m_lives, m_score, m_ticks, m_rstn;
    bit m_b1, m_b2, m_b3;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Button samples before reset release count as "held", so a press must be seen low first.
    task automatic model_reset();
        m_state = S_IDLE;
        m_lives = 0;
        m_score = 0;
        m_ticks = 0;
        m_rstn  = 0;
        m_b1 = 1'b1;
        m_b2 = 1'b1;
        m_b3 = 1'b1;
    endtask

    task automatic model_step(input bit btn, input bit tick, input bit lost, input bit hit);
        bit rise;
        int prev_state;
        rise = m_b2 && !m_b3;
        m_b3 = m_b2;
        m_b2 = m_b1;
        m_b1 = btn;
        prev_state = m_state;
        case (prev_state)
            S_IDLE: if (rise) begin
                m_lives = LI;
                m_score = 0;
                m_state = S_SERVE;
            end
            S_SERVE: if (tick) begin
                m_ticks++;
                if (m_ticks == SF) m_state = S_PLAY;
            end
            S_PLAY: begin
                if (hit && m_score < 255) m_score++;
                if (lost) begin
                    if (m_lives > 0) m_lives--;
                    m_state = S_LOST;
                end
`ifdef GAME_SEQ_CTRL_PAUSE_EN
                else if (rise) m_state = S_PAUSE;
`endif
            end
`ifdef GAME_SEQ_CTRL_PAUSE_EN
            S_PAUSE: if (rise) m_state = S_PLAY;
`endif
            S_LOST: if (tick) begin
                m_ticks++;
                if (m_ticks == LF) m_state = (m_lives > 0) ? S_SERVE : S_OVER;
            end
            S_OVER: if (rise) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
        if (m_state != prev_state) m_ticks = 0;
        m_rstn = (m_state == S_SERVE && prev_state != S_SERVE) ? 0 : 1;
    endtask

    task automatic check_all();
        check("state", int'(state), m_state);
        check("lives", int'(lives), m_lives);
        check("score", int'(score), m_score);
        check("eng_rst_n", int'(eng_rst_n), m_rstn);
        check("eng_run", int'(eng_run), (m_state == S_PLAY) ? 1 : 0);
        check("overlay_en", int'(overlay_en), (m_state == S_IDLE || m_state == S_OVER) ? 1 : 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_eng_rst_n"}, int'(eng_rst_n), 0);
        check({tag, "_eng_run"}, int'(eng_run), 0);
        check({tag, "_overlay_en"}, int'(overlay_en), 1);
        check({tag, "_lives"}, int'(lives), 0);
        check({tag, "_score"}, int'(score), 0);
    endtask

    // Called from the falling edge: drive, let the DUT clock, then compare on the next fall.
    task automatic cycle(input bit btn, input bit tick, input bit lost, input bit hit);
        btn_start  = btn;
        frame_tick = tick;
        ball_lost  = lost;
        brick_hit  = hit;
        @(posedge clk);
        model_step(btn, tick, lost, hit);
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        btn_start = 1'b0;
    endtask

    initial begin
        bit rb;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Start latency: state changes on the third edge after the pin rises.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_not_yet", int'(state), S_IDLE);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_state", int'(state), S_SERVE);
        check("start_rstn_low", int'(eng_rst_n), 0);
        check("start_lives", int'(lives), LI);
        check("start_score", int'(score), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rstn_one_cycle", int'(eng_rst_n), 1);

        ticks(SF - 1);
        check("serve_hold", int'(state), S_SERVE);
        ticks(1);
        check("play_state", int'(state), S_PLAY);
        check("play_run", int'(eng_run), 1);

        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("score_sat", int'(score), 255);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("hitlost_state", int'(state), S_LOST);
        check("hitlost_lives", int'(lives), 2);
        check("hitlost_score", int'(score), 255);

        ticks(LF);
        check("lost_to_serve", int'(state), S_SERVE);
        ticks(SF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lives_1", int'(lives), 1);
        ticks(LF);
        ticks(SF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lives_0", int'(lives), 0);
        ticks(LF);
        check("over_state", int'(state), S_OVER);
        check("over_overlay", int'(overlay_en), 1);
        check("over_score_hold", int'(score), 255);
        press();
        check("over_to_idle", int'(state), S_IDLE);

        // Second game: simultaneous hit and loss from a non-saturated score.
        press();
        check("game2_serve", int'(state), S_SERVE);
        ticks(SF);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("hitlost2_score", int'(score), 1);
        check("hitlost2_lives", int'(lives), 2);
        check("hitlost2_state", int'(state), S_LOST);
        ticks(LF);
        ticks(SF);
        press();
`ifdef GAME_SEQ_CTRL_PAUSE_EN
        check("pause_state", int'(state), S_PAUSE);
        check("pause_run", int'(eng_run), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("pause_ignore_state", int'(state), S_PAUSE);
        check("pause_ignore_lives", int'(lives), 2);
        press();
        check("resume_state", int'(state), S_PLAY);
`else
        check("play_start_ignored", int'(state), S_PLAY);
`endif
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("score_10", int'(score), 10);

        // Asynchronous abort between clock edges, with the button held through release.
        #2 reset = 1'b0;
        #1 check_reset_vals("abort");
        model_reset();
        btn_start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_no_start", int'(state), S_IDLE);

        rb = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            cycle(rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
